// File: rtl/apb_pkg.sv
// Shared APB definitions: requester/completer FSM states and pprot encodings.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [2:0] APB_PROT_NORMAL = 3'b000;
  localparam logic [2:0] APB_PROT_PRIV   = 3'b001;
  localparam logic [2:0] APB_PROT_NONSEC = 3'b010;
  localparam logic [2:0] APB_PROT_INSTR  = 3'b100;

endpackage

// File: rtl/apb_cmd_master.sv
// APB4 requester: one valid/ready command becomes one SETUP/ACCESS transfer,
// with a wait-state timeout and a registered valid/ready response.
module apb_cmd_master #(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [G_REGWIDTH-1:0]     cmd_wdata,
  input  logic [G_REGWIDTH/8-1:0]   cmd_wstrb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [G_REGWIDTH-1:0]     rsp_rdata,
  output logic                      rsp_timeout,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [2:0]                m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                      m_apb_pready,
  input  logic [G_REGWIDTH-1:0]     m_apb_prdata
);
  import apb_pkg::*;

  localparam int               CNT_W    = (G_TIMEOUT > 0) ? $clog2(G_TIMEOUT + 1) : 1;
  localparam bit               TMO_EN   = (G_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(G_TIMEOUT - 1);

  apb_state_e                state_q, state_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [2:0]                pprot_q, pprot_d;
  logic [G_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [G_REGWIDTH-1:0]     pwdata_q, pwdata_d;
  logic [G_REGWIDTH/8-1:0]   pstrb_q, pstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [G_REGWIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pprot_d       = pprot_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          pprot_d   = cmd_prot;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_wstrb : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        // pready is checked first so a completion on the last allowed cycle still succeeds
        if (m_apb_pready) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : m_apb_prdata;
          rsp_timeout_d = 1'b0;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pprot_q       <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pprot_q       <= pprot_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE) && rst;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pprot   = pprot_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus randomized bench for apb_cmd_master; the completer and the
// expected transfer shape are derived per command from its wait count.
module tb_apb_cmd_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        m_apb_psel;
  logic        m_apb_penable;
  logic        m_apb_pwrite;
  logic [2:0]  m_apb_pprot;
  logic [31:0] m_apb_paddr;
  logic [31:0] m_apb_pwdata;
  logic [3:0]  m_apb_pstrb;
  logic        m_apb_pready = 1'b0;
  logic [31:0] m_apb_prdata = '0;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  apb_cmd_master #(
    .G_REGWIDTH  (32),
    .G_ADDR_WIDTH(32),
    .G_TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .cmd_prot     (cmd_prot),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_timeout  (rsp_timeout),
    .m_apb_psel   (m_apb_psel),
    .m_apb_penable(m_apb_penable),
    .m_apb_pwrite (m_apb_pwrite),
    .m_apb_pprot  (m_apb_pprot),
    .m_apb_paddr  (m_apb_paddr),
    .m_apb_pwdata (m_apb_pwdata),
    .m_apb_pstrb  (m_apb_pstrb),
    .m_apb_pready (m_apb_pready),
    .m_apb_prdata (m_apb_prdata)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic chk_bus(input string ph, input bit sel, input bit en, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [2:0] prot);
    chk({ph, "_psel"}, 64'(m_apb_psel), 64'(sel));
    chk({ph, "_penable"}, 64'(m_apb_penable), 64'(en));
    chk({ph, "_pwrite"}, 64'(m_apb_pwrite), 64'(wr));
    chk({ph, "_paddr"}, 64'(m_apb_paddr), 64'(addr));
    chk({ph, "_pwdata"}, 64'(m_apb_pwdata), 64'(wd));
    chk({ph, "_pstrb"}, 64'(m_apb_pstrb), 64'(strb));
    chk({ph, "_pprot"}, 64'(m_apb_pprot), 64'(prot));
  endtask

  // One full transfer. Completer holds pready low for 'waits' ACCESS cycles.
  // Reference: ACCESS lasts min(waits+1, TMO) cycles; timeout iff waits >= TMO.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot,
                         input int waits, input int rdly, input bit pend);
    int          n_acc;
    bit          tmo;
    logic [31:0] exp_wd, exp_rd;
    logic [3:0]  exp_st;
    tmo    = (waits >= TMO);
    n_acc  = tmo ? TMO : waits + 1;
    exp_wd = wr ? data : 32'h0;
    exp_st = wr ? strb : 4'h0;
    exp_rd = (wr || tmo) ? 32'h0 : data;
    txn++;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb; cmd_prot = prot;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom); cmd_prot = 3'($urandom);
    chk_bus("setup", 1'b1, 1'b0, wr, addr, exp_wd, exp_st, prot);
    chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
    m_apb_pready = 1'($urandom);
    m_apb_prdata = $urandom;
    tick();
    for (int k = 0; k < n_acc; k++) begin
      chk_bus("access", 1'b1, 1'b1, wr, addr, exp_wd, exp_st, prot);
      chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
      m_apb_pready = (k == waits);
      m_apb_prdata = (k == waits) ? data : $urandom;
      tick();
    end
    m_apb_pready = 1'b0;
    m_apb_prdata = $urandom;
    chk("resp_psel", 64'(m_apb_psel), 64'd0);
    chk("resp_penable", 64'(m_apb_penable), 64'd0);
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_timeout", 64'(rsp_timeout), 64'(tmo));
    chk("resp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    for (int r = 0; r < rdly; r++) begin
      rsp_ready = 1'b0;
      if (pend) begin
        cmd_valid = 1'b1; cmd_addr = $urandom; cmd_write = 1'($urandom);
      end
      tick();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rdata", 64'(rsp_rdata), 64'(exp_rd));
      chk("stall_timeout", 64'(rsp_timeout), 64'(tmo));
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("stall_psel", 64'(m_apb_psel), 64'd0);
    end
    rsp_ready = 1'b1;
    if (pend) cmd_valid = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_psel", 64'(m_apb_psel), 64'd0);
    $display("txn %0d wr=%0d addr=%08h data=%08h waits=%0d timeout=%0d rdata=%08h",
             txn, wr, addr, data, waits, tmo, rsp_rdata);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk_bus("rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    rst = 1'b1;
    #1 chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // Directed: zero-wait write, waited read, timeout, timeout boundary
    run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, apb_pkg::APB_PROT_NORMAL, 0, 0, 1'b0);
    run_cmd(1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, apb_pkg::APB_PROT_PRIV, 3, 0, 1'b0);
    run_cmd(1'b0, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, apb_pkg::APB_PROT_NONSEC, 20, 0, 1'b0);
    run_cmd(1'b0, 32'h0000_0040, 32'hA5A5_5A5A, 4'h3, apb_pkg::APB_PROT_INSTR, TMO - 1, 0, 1'b0);
    run_cmd(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h5, 3'h7, TMO, 0, 1'b0);

    // Response stall with a second command pending, then that command
    run_cmd(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hC, 3'h1, 1, 5, 1'b1);
    chk("pend_no_setup", 64'(m_apb_psel), 64'd0);
    run_cmd(1'b0, 32'h0000_0054, 32'h7777_8888, 4'hF, 3'h2, 2, 0, 1'b0);

    // Reset during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0060; cmd_prot = 3'h5;
    tick();
    cmd_valid = 1'b0;
    m_apb_pready = 1'b0;
    tick(); tick();
    chk("pre_rst_penable", 64'(m_apb_penable), 64'd1);
    rst = 1'b0;
    tick();
    chk_bus("midrst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    #1 chk("midrst_rel_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      m_apb_pready = 1'b1;
      tick();
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("midrst_idle_psel", 64'(m_apb_psel), 64'd0);
    end
    m_apb_pready = 1'b0;
    $display("txn reset-abort addr=00000060 no response");

    // Randomized commands, waits and response back-pressure
    for (int n = 0; n < 1000; n++) begin
      run_cmd(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
              (n < 999) ? 1'($urandom) : 1'b0);
    end
    cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
